// File: rtl/mfcc_seq_ctrl_pkg.sv
// Shared MFCC constants: stage encodings, default sizes and sequencer state type.
// Datapath stage case selection keys off the same mfcc_stage_e values.
package mfcc_seq_ctrl_pkg;

  localparam int NUM_STAGES_DEF = 7;
  localparam int NUM_COEF_DEF   = 12;
  localparam int TIMEOUT_DEF    = 4096;

  typedef enum logic [2:0] {
    STG_NONE = 3'd0,
    STG_HAM  = 3'd1,
    STG_FFT  = 3'd2,
    STG_POW  = 3'd3,
    STG_MEL  = 3'd4,
    STG_DCT  = 3'd5,
    STG_PICK = 3'd6,
    STG_LIFT = 3'd7
  } mfcc_stage_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_OUTPUT = 3'd3,
    ST_FINISH = 3'd4
  } seq_state_e;

  // The RAM address leads the streamed index by one because of the read latency.
  function automatic logic [4:0] coef_index(input logic [3:0] addr);
    return {1'b0, addr};
  endfunction

endpackage

// File: rtl/mfcc_wdog.sv
// Stage watchdog: counts enabled cycles since the last clear and flags expiry
// on the TIMEOUT-th enabled cycle; holds its count once expired.
module mfcc_wdog
  import mfcc_seq_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expired = enable && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mfcc_seq_ctrl.sv
// MFCC frame sequencer: launches the per-frame stages in order, streams the
// coefficient RAM out, and tracks pending/overrun/timeout conditions.
//
// Handshake: frame_rdy and stage_done are single-cycle pulses sampled on the
// rising clock edge; stage_go is a single-cycle pulse; dv_out qualifies
// out_index on every cycle it is high, with no back-pressure from the sink.
module mfcc_seq_ctrl
  import mfcc_seq_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int NUM_COEF   = NUM_COEF_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_rdy,
  input  logic        stage_done,
  input  logic        err_clr,
  output logic        stage_go,
  output logic [2:0]  stage_sel,
  output logic [3:0]  coef_addr,
  output logic        dv_out,
  output logic [4:0]  out_index,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err,
  output logic [15:0] frame_cnt,
  output seq_state_e  state_dbg
);

  seq_state_e state;
  logic       pending;
  logic       wd_expired;

  assign state_dbg = state;

  mfcc_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == ST_LAUNCH),
    .enable  (state == ST_WAIT),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      stage_go    <= 1'b0;
      stage_sel   <= 3'd0;
      coef_addr   <= 4'd0;
      dv_out      <= 1'b0;
      out_index   <= 5'd0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= 16'd0;
      pending     <= 1'b0;
    end else begin
      stage_go <= 1'b0;

      // Clear first so that an error event later in this block wins.
      if (err_clr) begin
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end

      if (frame_rdy && (state != ST_IDLE)) begin
        if (pending) begin
          overrun <= 1'b1;
        end else begin
          pending <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (frame_rdy || pending) begin
            state     <= ST_LAUNCH;
            stage_sel <= STG_HAM;
            stage_go  <= 1'b1;
            busy      <= 1'b1;
            // A fresh frame arriving while a pending one starts stays queued.
            pending   <= frame_rdy && pending;
          end
        end

        ST_LAUNCH: begin
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (stage_done) begin
            if (stage_sel == 3'(NUM_STAGES)) begin
              state     <= ST_OUTPUT;
              stage_sel <= STG_NONE;
              coef_addr <= 4'd0;
              dv_out    <= 1'b0;
            end else begin
              state     <= ST_LAUNCH;
              stage_sel <= stage_sel + 3'd1;
              stage_go  <= 1'b1;
            end
          end else if (wd_expired) begin
            state       <= ST_IDLE;
            stage_sel   <= STG_NONE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end
        end

        ST_OUTPUT: begin
          if (coef_addr == 4'(NUM_COEF)) begin
            state     <= ST_FINISH;
            coef_addr <= 4'd0;
            dv_out    <= 1'b0;
            out_index <= 5'd0;
            frame_cnt <= frame_cnt + 16'd1;
          end else begin
            coef_addr <= coef_addr + 4'd1;
            dv_out    <= 1'b1;
            out_index <= coef_index(coef_addr);
          end
        end

        ST_FINISH: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state     <= ST_IDLE;
          stage_sel <= STG_NONE;
          coef_addr <= 4'd0;
          dv_out    <= 1'b0;
          out_index <= 5'd0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  a_go_only_in_launch: assert property (@(posedge clk) disable iff (reset)
    stage_go |-> (state == ST_LAUNCH));
  a_dv_only_in_output: assert property (@(posedge clk) disable iff (reset)
    dv_out |-> (state == ST_OUTPUT));
  a_busy_tracks_state: assert property (@(posedge clk) disable iff (reset)
    busy == (state != ST_IDLE));

endmodule
